// File: rtl/memory_request_unit.sv
// memory_request_unit
//   Sequences the memory traffic of one instruction in the single-cycle
//   datapath. Each instruction gets one fetch, then at most one data access.
//   The unit latches HALT, flags a fetch that carries both a read and a write
//   request, and stops with a watchdog error if an awaited hit never arrives.
//
//   Ports
//     CLK, RST      clock; synchronous active-high reset
//     ihit, dhit    instruction / data access complete (memory controller)
//     dR_REQ        current instruction reads data memory
//     dW_REQ        current instruction writes data memory
//     halt          current instruction is HALT
//     imemREN       instruction read enable
//     dmemREN       data read enable
//     dmemWEN       data write enable
//     pc_en         pulse: PC advances at the next edge
//     wb_en         pulse: register-file write may commit this cycle
//     halted        sticky: HALT retired or watchdog expired
//     err_both      sticky: read and write requested together at ihit
//     err_timeout   sticky: watchdog expired
//     dacc_count    completed data accesses, saturating
//
//   state  | meaning
//   FETCH  | instruction read in flight, waiting for ihit
//   DATA   | data read or write in flight, waiting for dhit
//   HALTED | stopped after HALT or watchdog expiry; only RST leaves
module memory_request_unit #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dR_REQ,
    input  logic             dW_REQ,
    input  logic             halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             wb_en,
    output logic             halted,
    output logic             err_both,
    output logic             err_timeout,
    output logic [CNT_W-1:0] dacc_count
);

    localparam bit          WD_ON   = (TIMEOUT != 0);
    localparam int          WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_ON ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              rd_q, rd_nxt;
    logic              wr_q, wr_nxt;
    logic [WD_W-1:0]   wd_cnt, wd_nxt;
    logic [CNT_W-1:0]  dacc_q, dacc_nxt;
    logic              err_both_q, err_both_nxt;
    logic              err_to_q, err_to_nxt;
    logic              awaited_hit;
    logic              wd_expire;
    logic              imem_ren, dmem_ren, dmem_wen, retire;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= FETCH;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wd_cnt     <= '0;
            dacc_q     <= '0;
            err_both_q <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_q       <= rd_nxt;
            wr_q       <= wr_nxt;
            wd_cnt     <= wd_nxt;
            dacc_q     <= dacc_nxt;
            err_both_q <= err_both_nxt;
            err_to_q   <= err_to_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_nxt       = rd_q;
        wr_nxt       = wr_q;
        dacc_nxt     = dacc_q;
        err_both_nxt = err_both_q;
        err_to_nxt   = err_to_q;
        imem_ren     = 1'b0;
        dmem_ren     = 1'b0;
        dmem_wen     = 1'b0;
        retire       = 1'b0;

        // Only the hit the current state is waiting for counts; the other
        // one is ignored, including by the watchdog.
        case (state)
            FETCH:   awaited_hit = ihit;
            DATA:    awaited_hit = dhit;
            default: awaited_hit = 1'b0;
        endcase

        // A hit arriving in the expiring cycle wins over the timeout.
        wd_expire = WD_ON && (state != HALTED) && !awaited_hit && (wd_cnt == WD_LAST);

        case (state)
            FETCH: begin
                imem_ren = 1'b1;
                if (ihit) begin
                    if (halt) begin
                        state_nxt = HALTED;
                    end else if (dR_REQ || dW_REQ) begin
                        rd_nxt    = dR_REQ & ~dW_REQ;
                        wr_nxt    = dW_REQ;
                        state_nxt = DATA;
                        if (dR_REQ && dW_REQ) err_both_nxt = 1'b1;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (wd_expire) begin
                    err_to_nxt = 1'b1;
                    state_nxt  = HALTED;
                end
            end
            DATA: begin
                dmem_ren = rd_q;
                dmem_wen = wr_q;
                if (dhit) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                    if (dacc_q != '1) dacc_nxt = dacc_q + 1'b1;
                end else if (wd_expire) begin
                    err_to_nxt = 1'b1;
                    state_nxt  = HALTED;
                end
            end
            default: begin
                state_nxt = HALTED;
            end
        endcase

        if (!WD_ON || (state == HALTED) || awaited_hit || (state_nxt != state))
            wd_nxt = '0;
        else
            wd_nxt = wd_cnt + 1'b1;
    end

    // Every output, registered or not, is forced low while RST is held.
    assign imemREN     = imem_ren & ~RST;
    assign dmemREN     = dmem_ren & ~RST;
    assign dmemWEN     = dmem_wen & ~RST;
    assign pc_en       = retire & ~RST;
    assign wb_en       = retire & ~RST;
    assign halted      = (state == HALTED) & ~RST;
    assign err_both    = err_both_q & ~RST;
    assign err_timeout = err_to_q & ~RST;
    assign dacc_count  = RST ? '0 : dacc_q;

endmodule
